// File: rtl/mult_ctrl.sv
// ---------------------------------------------------------------------------
// mult_ctrl
//   Control FSM for a sequential shift-add multiplier. It loads the operands,
//   clears the accumulator, then performs WIDTH test/add/shift iterations.
//   Each iteration inspects the multiplier LSB (q0) and conditionally adds the
//   multiplicand before shifting the accumulator:multiplier pair right.
//   Outputs are Moore decodes of the state register, except cnt, which is a
//   separate down-counter of the remaining iterations.
//
// Ports
//   clk      in   system clock, rising-edge active
//   reset    in   synchronous active-low reset
//   start    in   begin one multiply (only honoured in IDLE)
//   q0       in   LSB of the multiplier shift register (sampled in TEST)
//   ld_a     out  load multiplicand register
//   ld_b     out  load multiplier shift register
//   clr_acc  out  clear accumulator
//   add_en   out  accumulator <= accumulator + multiplicand
//   shift_en out  shift accumulator:multiplier right by one
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   cnt      out  remaining iterations
// ---------------------------------------------------------------------------
module mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          q0,
  output logic          ld_a,
  output logic          ld_b,
  output logic          clr_acc,
  output logic          add_en,
  output logic          shift_en,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_nextState;
  logic [CW-1:0] r_cnt;

  // Next-state logic. start is only looked at in IDLE, so a request made
  // while busy is simply dropped. The last iteration is detected from the
  // counter value on entry to SHIFT (1 means this shift is the final one);
  // treating 0 the same way keeps a corrupted counter from looping forever.
  // Unused encodings fall back to IDLE.
  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:  w_nextState = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_nextState = S_TEST;
      S_TEST:  w_nextState = q0 ? S_ADD : S_SHIFT;
      S_ADD:   w_nextState = S_SHIFT;
      S_SHIFT: w_nextState = (r_cnt <= CW'(1)) ? S_DONE : S_TEST;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register. Reset wins over everything, including a pending start,
  // and aborts a multiply in flight without ever reaching DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Iteration counter: preset in LOAD, decremented once per SHIFT and held
  // everywhere else. The decrement is guarded so the counter cannot wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_cnt <= CW'(WIDTH);
    end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Moore output decodes; the strobe groups are one-hot by construction.
  assign ld_a     = (r_state == S_LOAD);
  assign ld_b     = (r_state == S_LOAD);
  assign clr_acc  = (r_state == S_LOAD);
  assign add_en   = (r_state == S_ADD);
  assign shift_en = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);
  assign cnt      = r_cnt;

endmodule
